// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search block.
package sar_pkg;

    localparam int unsigned SarWidthDefault = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sar_state_e;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search FSM driving an external comparator (a=target, b=guess).
// Optional early exit on eq is enabled by defining SAR_EARLY_EXIT_EN.
module sar_search
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SarWidthDefault
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] TopBit = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] OneVal = {{(WIDTH-1){1'b0}}, 1'b1};

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] decided;
    logic             protocol_err;
    logic             clear_bit;

`ifndef SAR_EARLY_EXIT_EN
    logic unused_eq;
    assign unused_eq = eq;
`endif

    // gt and lt together is a comparator fault; resolve it as lt so the result stays deterministic.
    assign protocol_err = gt & lt;
    assign clear_bit    = lt | protocol_err;
    assign bit_mask     = OneVal << idx_q;
    assign decided      = clear_bit ? (guess_q & ~bit_mask) : guess_q;

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    guess_d = TopBit;
                    idx_d   = IdxW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
`ifdef SAR_EARLY_EXIT_EN
                if (eq) begin
                    result_d = guess_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else
`endif
                if (idx_q == '0) begin
                    result_d = decided;
                    guess_d  = decided;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    guess_d = decided | (bit_mask >> 1);
                    idx_d   = idx_q - IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign guess  = guess_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
